ola_seq_ctrl: RTL and testbench
===============================

Name: ola_seq_ctrl

Overview:
Sequencer for the 4-lane overlap-add datapath (pcm1+pcm2 adder with load/action strobes). For one half window it does three things per 4-sample beat: fetches the previous-frame tail word and the current-frame head word from the PCM buffer, strobes them into the datapath as pcm1 then pcm2, and streams the summed word out over a valid/ready handshake. It sits between the frame buffer and the PCM output FIFO and is started once per frame by the decoder top FSM.

Parameters:
WORD_LENGTH, 16, bits per PCM sample
LANES, 4, samples per bus word
HALF_WINDOW_SIZE, 512, samples per overlap region
BUS_SIZE, LANES*WORD_LENGTH (64), bus word width
BEATS, HALF_WINDOW_SIZE/LANES (128), words per overlap
BEAT_W, $clog2(BEATS) (7), beat counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to run one overlap; ignored while busy
busy  out  1  high from the cycle after an accepted start through DONE
done  out  1  one-cycle pulse after the last word is accepted
rd_en  out  1  buffer read strobe; buffer latency is 1 cycle
rd_sel  out  1  0 = previous-frame tail, 1 = current-frame head
rd_addr  out  BEAT_W  word index within the selected half
rd_data  in  BUS_SIZE  buffer read data, valid the cycle after rd_en
load  out  1  datapath load strobe
dp_data_in  out  BUS_SIZE  word driven to the datapath (= rd_data, combinational)
action  out  1  datapath output enable
dp_data_out  in  BUS_SIZE  datapath sum word
out_valid  out  1  output word valid
out_ready  in  1  downstream ready
out_data  out  BUS_SIZE  = dp_data_out while out_valid
out_addr  out  BEAT_W  beat index of out_data

Behaviour:
- Reset: clock and reset are as given in Ports (synchronous, active-high). Reset forces state IDLE and beat=0. Every output goes to 0: busy, done, rd_en, rd_sel, rd_addr, load, action, out_valid, out_addr. dp_data_in and out_data are don't-care but are driven as 0.
- Reset mid-operation abandons the frame. No done pulse is generated.
- States and per-state outputs:
  - IDLE: all strobes 0. start=1 -> FETCH_A, beat cleared to 0.
  - FETCH_A: rd_en=1, rd_sel=0, rd_addr=beat. -> LOAD_A.
  - LOAD_A: load=1 with dp_data_in=rd_data (tail word, latched as pcm1); rd_en=1, rd_sel=1, rd_addr=beat. -> LOAD_B.
  - LOAD_B: load=1 with dp_data_in=rd_data (head word, latched as pcm2). -> SETTLE.
  - SETTLE: no strobes; the datapath registers its sum on this edge. -> OUTPUT.
  - OUTPUT: action=1, out_valid=1, out_addr=beat; load stays 0, so the datapath's first/second toggle is cleared.
    - out_valid and out_data are held stable until out_ready=1.
    - On handshake with beat==BEATS-1 -> DONE.
    - Otherwise beat increments and the FSM goes to FETCH_A.
  - DONE: done=1 for exactly one cycle. -> IDLE.
- busy=1 in every state except IDLE.
- Latency: 5 cycles per beat when out_ready is held high; 641 cycles from the accepted start to the done pulse (start cycle in IDLE, 128×5, plus DONE).
- load is never high in two non-consecutive cycles of the same beat. The pair is always LOAD_A followed by LOAD_B.
- Boundaries:
  - beat is never wrapped in-frame; the last beat exits to DONE.
  - start in DONE or any busy state is dropped.
  - start in the same cycle as reset: reset wins.
  - out_ready high outside OUTPUT has no effect.

Optional Feature:
Macro OLA_SEQ_STALL_CNT_EN.
- When defined: adds output port stall_cycles (16 bits).
  - Counts OUTPUT cycles with out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on an accepted start; holds its value after done.
- When undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package ola_pkg holds:
  - localparams WORD_LENGTH, LANES, HALF_WINDOW_SIZE, BUS_SIZE, BEATS, BEAT_W
  - typedef logic [BUS_SIZE-1:0] pcm_word_t
  - typedef logic [BEAT_W-1:0] beat_t
  - typedef enum ola_state_t {IDLE, FETCH_A, LOAD_A, LOAD_B, SETTLE, OUTPUT, DONE}
- No sub-module: a single FSM plus beat counter. The stall counter stays inline under the macro.

Test Plan:
- Reset, then a start pulse with out_ready=1 and a behavioural datapath model. Tail word k = {4{16'(k)}}, head word k = {4{16'(2k)}}.
  -> 128 outputs, out_data[k] = {4{16'(3k)}}, out_addr 0..127 in order, done exactly once at cycle 641, busy low afterwards.
- Per-beat strobe check on beat 5. -> rd_en on 2 consecutive cycles with rd_sel 0 then 1 and rd_addr=5; load on the next 2 consecutive cycles; action only in OUTPUT.
- Backpressure: out_ready held 0 for 10 cycles at beat 3.
  -> out_valid, out_data and out_addr stable all 10 cycles, no new rd_en.
  -> With OLA_SEQ_STALL_CNT_EN, stall_cycles=10 at done.
- start pulsed at beats 0, 64 and 127 while busy -> ignored; exactly one done and 128 outputs.
- Reset asserted during LOAD_B of beat 40 -> next cycle all outputs 0 and state IDLE, no done. A subsequent start produces a full 128-beat run from beat 0.
- Back-to-back frames: start issued in the cycle after done -> second run accepted, 128 outputs, out_addr restarts at 0.

Source files
------------

// File: rtl/ola_pkg.sv
// Shared sizes, word/beat types and FSM encoding for the overlap-add sequencer.
// Optional stall counter in ola_seq_ctrl is enabled by defining OLA_SEQ_STALL_CNT_EN.
package ola_pkg;

  localparam int WORD_LENGTH      = 16;
  localparam int LANES            = 4;
  localparam int HALF_WINDOW_SIZE = 512;
  localparam int BUS_SIZE         = LANES * WORD_LENGTH;
  localparam int BEATS            = HALF_WINDOW_SIZE / LANES;
  localparam int BEAT_W           = $clog2(BEATS);

  typedef logic [BUS_SIZE-1:0] pcm_word_t;
  typedef logic [BEAT_W-1:0]   beat_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    LOAD_A,
    LOAD_B,
    SETTLE,
    OUTPUT,
    DONE
  } ola_state_t;

  localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

endpackage

// File: rtl/ola_seq_ctrl.sv
// Overlap-add sequencer: per beat fetches tail/head words, loads the datapath, streams the sum.
// Define OLA_SEQ_STALL_CNT_EN to add the saturating stall_cycles output.
module ola_seq_ctrl
  import ola_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      start,
  output logic      busy,
  output logic      done,
  output logic      rd_en,
  output logic      rd_sel,
  output beat_t     rd_addr,
  input  pcm_word_t rd_data,
  output logic      load,
  output pcm_word_t dp_data_in,
  output logic      action,
  input  pcm_word_t dp_data_out,
  output logic      out_valid,
  input  logic      out_ready,
  output pcm_word_t out_data,
  output beat_t     out_addr
`ifdef OLA_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  ola_state_t state_q, state_d;
  beat_t      beat_q, beat_d;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first; a missed branch would infer a latch.
    state_d    = state_q;
    beat_d     = beat_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    rd_en      = 1'b0;
    rd_sel     = 1'b0;
    rd_addr    = '0;
    load       = 1'b0;
    dp_data_in = '0;
    action     = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_addr   = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH_A;
          beat_d  = '0;
        end
      end
      FETCH_A: begin
        rd_en   = 1'b1;
        rd_sel  = 1'b0;
        rd_addr = beat_q;
        state_d = LOAD_A;
      end
      LOAD_A: begin
        // Tail word arrives now; the head read is issued in the same cycle.
        load       = 1'b1;
        dp_data_in = rd_data;
        rd_en      = 1'b1;
        rd_sel     = 1'b1;
        rd_addr    = beat_q;
        state_d    = LOAD_B;
      end
      LOAD_B: begin
        load       = 1'b1;
        dp_data_in = rd_data;
        state_d    = SETTLE;
      end
      SETTLE: begin
        state_d = OUTPUT;
      end
      OUTPUT: begin
        action    = 1'b1;
        out_valid = 1'b1;
        out_data  = dp_data_out;
        out_addr  = beat_q;
        if (out_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = FETCH_A;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef OLA_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q == OUTPUT && !out_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ola_seq_ctrl.sv
// Self-checking bench for ola_seq_ctrl with behavioural PCM buffer and overlap-add datapath.
module tb_ola_seq_ctrl;
  import ola_pkg::*;

  logic      clock, reset, start;
  logic      busy, done, rd_en, rd_sel, load, action, out_valid, out_ready;
  beat_t     rd_addr, out_addr;
  pcm_word_t rd_data, dp_data_in, dp_data_out, out_data;
`ifdef OLA_SEQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  ola_seq_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_sel      (rd_sel),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .load        (load),
    .dp_data_in  (dp_data_in),
    .action      (action),
    .dp_data_out (dp_data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr)
`ifdef OLA_SEQ_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic pcm_word_t splat(input int v);
    pcm_word_t w;
    for (int l = 0; l < LANES; l++) w[l*WORD_LENGTH +: WORD_LENGTH] = WORD_LENGTH'(v);
    return w;
  endfunction

  function automatic pcm_word_t add_lanes(input pcm_word_t a, input pcm_word_t b);
    pcm_word_t s;
    for (int l = 0; l < LANES; l++)
      s[l*WORD_LENGTH +: WORD_LENGTH] = a[l*WORD_LENGTH +: WORD_LENGTH] + b[l*WORD_LENGTH +: WORD_LENGTH];
    return s;
  endfunction

  // Frame buffer: tail word k = {4{k}}, head word k = {4{2k}}, one-cycle read latency.
  always @(posedge clock) begin
    if (rd_en) rd_data <= rd_sel ? splat(2 * int'(rd_addr)) : splat(int'(rd_addr));
    else       rd_data <= '0;
  end

  // Datapath: first load -> pcm1, second -> pcm2; any cycle without load clears the toggle.
  pcm_word_t pcm1, pcm2, sum_q;
  logic      second_q;
  always @(posedge clock) begin
    if (reset) begin
      second_q <= 1'b0;
    end else if (load) begin
      if (!second_q) pcm1 <= dp_data_in;
      else           pcm2 <= dp_data_in;
      second_q <= ~second_q;
    end else begin
      second_q <= 1'b0;
    end
    sum_q <= add_lanes(pcm1, pcm2);
  end
  assign dp_data_out = sum_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    beat_t     addr;
    pcm_word_t data;
  } exp_t;

  exp_t sb[$];
  int   frame_outs = 0;
  int   done_cnt   = 0;
  int   done_cyc   = 0;
  int   start_cyc  = 0;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(out_addr), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("out_addr", 64'(out_addr), 64'(e.addr));
        check("out_data", out_data, e.data);
      end
      frame_outs++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"},       64'(busy),      0);
    check({tag, "_done"},       64'(done),      0);
    check({tag, "_rd_en"},      64'(rd_en),     0);
    check({tag, "_rd_sel"},     64'(rd_sel),    0);
    check({tag, "_rd_addr"},    64'(rd_addr),   0);
    check({tag, "_load"},       64'(load),      0);
    check({tag, "_action"},     64'(action),    0);
    check({tag, "_out_valid"},  64'(out_valid), 0);
    check({tag, "_out_addr"},   64'(out_addr),  0);
    check({tag, "_dp_data_in"}, dp_data_in,     0);
    check({tag, "_out_data"},   out_data,       0);
  endtask

  // Caller must be positioned just after a rising edge.
  task automatic start_frame();
    exp_t e;
    sb.delete();
    for (int k = 0; k < BEATS; k++) begin
      e.addr = beat_t'(k);
      e.data = splat(3 * k);
      sb.push_back(e);
    end
    frame_outs = 0;
    done_cnt   = 0;
    #1 start = 1'b1;
    start_cyc = cyc;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_rd(input int addr, input logic sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (rd_en && rd_sel == sel && int'(rd_addr) == addr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_out(input int addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (out_valid && int'(out_addr) == addr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns just after the rising edge that ends the DONE cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock);
      if (done_cnt != 0) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 1);
    check({tag, "_latency"},   64'(done_cyc - start_cyc), 64'(exp_lat));
    check({tag, "_outputs"},   64'(frame_outs), 64'(BEATS));
    check({tag, "_sb_empty"},  64'(sb.size()), 0);
    check({tag, "_done_once"}, 64'(done_cnt), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit        ok;
    pcm_word_t hold_data;
    beat_t     hold_addr;
    int        pulse_beats[3];

    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
`ifdef OLA_SEQ_STALL_CNT_EN
    check("reset_stall", 64'(stall_cycles), 0);
`endif
    @(posedge clock); #1 reset = 1'b0;

    // start coincident with reset is dropped
    @(posedge clock); #1 reset = 1'b1; start = 1'b1;
    @(posedge clock); #1 reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("rst_start_busy", 64'(busy), 0);
    @(negedge clock);
    check("rst_start_rd_en", 64'(rd_en), 0);

    // Frame A: full run with strobe check on beat 5
    @(posedge clock);
    start_frame();
    wait_rd(5, 1'b0, ok);
    check("b5_fetch_found", 64'(ok), 1);
    check("b5_fetch_load", 64'(load), 0);
    check("b5_fetch_action", 64'(action), 0);
    @(negedge clock);
    check("b5_loada_rd_en", 64'(rd_en), 1);
    check("b5_loada_rd_sel", 64'(rd_sel), 1);
    check("b5_loada_rd_addr", 64'(rd_addr), 5);
    check("b5_loada_load", 64'(load), 1);
    check("b5_loada_dp_in", dp_data_in, splat(5));
    @(negedge clock);
    check("b5_loadb_rd_en", 64'(rd_en), 0);
    check("b5_loadb_load", 64'(load), 1);
    check("b5_loadb_dp_in", dp_data_in, splat(10));
    check("b5_loadb_action", 64'(action), 0);
    @(negedge clock);
    check("b5_settle_load", 64'(load), 0);
    check("b5_settle_rd_en", 64'(rd_en), 0);
    check("b5_settle_action", 64'(action), 0);
    @(negedge clock);
    check("b5_out_action", 64'(action), 1);
    check("b5_out_valid", 64'(out_valid), 1);
    check("b5_out_addr", 64'(out_addr), 5);
    check("b5_out_load", 64'(load), 0);
    wait_done("A", 641);

    // Frame B: back-to-back start, 10 cycles of backpressure at beat 3
    start_frame();
    wait_rd(3, 1'b1, ok);
    check("bp_found", 64'(ok), 1);
    @(posedge clock); #1 out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    hold_data = out_data;
    hold_addr = out_addr;
    check("bp_first_addr", 64'(out_addr), 3);
    check("bp_first_data", out_data, splat(9));
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clock);
      check("bp_valid", 64'(out_valid), 1);
      check("bp_data_stable", out_data, hold_data);
      check("bp_addr_stable", 64'(out_addr), 64'(hold_addr));
      check("bp_no_rd", 64'(rd_en), 0);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    wait_done("B", 651);
`ifdef OLA_SEQ_STALL_CNT_EN
    check("B_stall_cycles", 64'(stall_cycles), 10);
`endif

    // Frame C: start pulses while busy and during DONE are ignored
    @(posedge clock);
    start_frame();
    pulse_beats = '{0, 64, 127};
    for (int p = 0; p < 3; p++) begin
      wait_out(pulse_beats[p], ok);
      check("pulse_found", 64'(ok), 1);
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
    wait_done("C", 641);
    repeat (5) @(negedge clock);
    check("C_idle_busy", 64'(busy), 0);
    check("C_single_done", 64'(done_cnt), 1);
    check("C_no_extra_out", 64'(frame_outs), 64'(BEATS));
`ifdef OLA_SEQ_STALL_CNT_EN
    check("C_stall_cycles", 64'(stall_cycles), 0);
`endif

    // Frame D: reset during LOAD_B of beat 40 abandons the frame
    @(posedge clock);
    start_frame();
    wait_rd(40, 1'b1, ok);
    check("abort_found", 64'(ok), 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_idle("abort");
    repeat (10) @(negedge clock);
    check("abort_no_done", 64'(done_cnt), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_outs", 64'(frame_outs), 40);

    // Frame E: full run from beat 0 after the abort
    @(posedge clock);
    start_frame();
    wait_done("E", 641);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
